ps2_keyboard_tx: RTL
====================

PS2_KEYBOARD_TX -- requirements
Module: ps2_keyboard_tx

Interface
REQ-001 SHALL provide parameter CLK_HALF, default 2500, meaning clk cycles per half PS/2 clock period.
REQ-002 SHALL provide parameter GAP_HALVES, default 4, meaning idle half-periods inserted after every frame's stop bit.
REQ-003 SHALL provide port clk  input  1  system clock, all logic on posedge.
REQ-004 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port tx_data  input  8  scan code to transmit.
REQ-006 SHALL provide port tx_release  input  1  key-release flag, sampled with tx_data.
REQ-007 SHALL provide port tx_valid  input  1  request, qualified by tx_ready.
REQ-008 SHALL provide port tx_ready  output  1  high only when idle and able to accept.
REQ-009 SHALL provide port ps2_clk  output  1  device-driven PS/2 clock, idle high.
REQ-010 SHALL provide port ps2_data  output  1  device-driven PS/2 data, idle high.
REQ-011 SHALL provide port busy  output  1  high from acceptance until return to IDLE.
REQ-012 SHALL provide port frame_done  output  1  one-cycle pulse per completed frame.

Function
REQ-013 SHALL accept a request on a posedge where tx_valid and tx_ready are both 1, capturing tx_data and tx_release; tx_valid while tx_ready=0 is ignored.
REQ-014 SHALL use frame format: start 0, data bits LSB first, odd parity (~^data), stop 1; 11 bits.
REQ-015 SHALL, per bit: drive ps2_data with ps2_clk=1 for CLK_HALF cycles (SETUP), then ps2_clk=0 for CLK_HALF cycles (LOW); ps2_data changes only while ps2_clk=1.
REQ-016 SHALL, on the accepting edge, set tx_ready=0, busy=1, ps2_data=0 (start), ps2_clk=1; first ps2_clk fall occurs CLK_HALF cycles later.
REQ-017 SHALL use states IDLE -> SETUP <-> LOW (11 bits) -> GAP -> IDLE, or GAP -> SETUP when a second frame is pending.
REQ-018 SHALL pulse frame_done for one cycle on the edge leaving LOW of bit 10 (ps2_clk returns 1, ps2_data=1).
REQ-019 SHALL hold ps2_clk=1, ps2_data=1 during GAP for GAP_HALVES*CLK_HALF cycles.
REQ-020 SHALL reach IDLE (tx_ready=1, busy=0) exactly (22+GAP_HALVES)*CLK_HALF cycles after acceptance for a single frame.
REQ-021 SHALL keep all outputs registered; no combinational input-to-output path.
REQ-022 SHALL wrap the half-period counter 0..CLK_HALF-1 and bit index 0..10; neither overflows for CLK_HALF up to 65535.

Reset
REQ-023 SHALL, while reset=1 (asynchronous), force ps2_clk=1, ps2_data=1, tx_ready=1, busy=0, frame_done=0, state IDLE, pending break cleared.
REQ-024 SHALL discard a frame interrupted by reset without a frame_done pulse; the next accepted request produces a complete frame.

Configuration
REQ-025 SHALL honour macro PS2_BREAK_EN: when defined, an accepted request with tx_release=1 sends frame 0xF0, then frame tx_data, with frame_done pulsing after each and busy held throughout.
REQ-026 SHALL, without PS2_BREAK_EN, ignore tx_release and send one frame of tx_data only.

Structure
REQ-027 SHALL place FRAME_BITS=11, BREAK_CODE=8'hF0 and the state enum in shared package ps2_pkg.
REQ-028 SHALL isolate the half-period counter in sub-module ps2_tick_gen (clk, reset, enable, tick output).

Verification (CLK_HALF=4, GAP_HALVES=4)
REQ-029 SHALL cover: reset asserted -> ps2_clk=1, ps2_data=1, tx_ready=1, busy=0, frame_done=0.
REQ-030 SHALL cover: tx_data=0x1C, tx_release=0 -> data sampled on ps2_clk falls is 0,0,0,1,1,1,0,0,0,0,1; frame_done once; tx_ready high 104 cycles after acceptance.
REQ-031 SHALL cover: tx_data=0x00 and 0xFF -> parity bit 1 in both.
REQ-032 SHALL cover: PS2_BREAK_EN defined, tx_data=0x1C, tx_release=1 -> frames 0xF0 (parity 1) then 0x1C, two frame_done pulses, ready after 208 cycles; macro undefined -> single 0x1C frame.
REQ-033 SHALL cover: tx_valid held high continuously -> frames never overlap, each separated by 16 idle-high cycles; requests during busy not captured.
REQ-034 SHALL cover: reset asserted during bit 5 LOW -> ps2_clk and ps2_data high immediately, no frame_done; subsequent 0x1C request yields a clean full frame.

Source files
------------

// File: rtl/ps2_pkg.sv
// ============================================================================
//  Module   : ps2_pkg
//  Purpose  : Shared definitions for the PS/2 keyboard transmitter: frame
//             length, break prefix code, FSM state encoding and a helper that
//             assembles an 11-bit frame (start, 8 data LSB first, odd parity,
//             stop) so that bit i of the result is the i-th bit on the wire.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

    localparam int          FRAME_BITS = 11;
    localparam logic [7:0]  BREAK_CODE = 8'hF0;
    localparam logic [3:0]  LAST_BIT   = 4'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_LOW   = 2'd2,
        ST_GAP   = 2'd3
    } ps2_state_t;

    // Index 0 is the start bit, index 10 the stop bit.
    function automatic logic [FRAME_BITS-1:0] ps2_frame(input logic [7:0] code);
        return {1'b1, ~^code, code, 1'b0};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_tick_gen.sv
// ============================================================================
//  Module   : ps2_tick_gen
//  Purpose  : Half-period timer. While enabled, counts 0..CLK_HALF-1 and
//             raises tick during the last count, so a phase that starts on the
//             edge where enable rises lasts exactly CLK_HALF clk cycles.
//             Disabled, the counter is held at zero.
//  Ports    : clk    - system clock
//             reset  - asynchronous active-high reset
//             enable - count while high, clear while low
//             tick   - high in the final cycle of each half period
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_tick_gen #(
    parameter int CLK_HALF = 2500
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int              CW       = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(CLK_HALF - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!enable) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = enable && (cnt_q == CNT_LAST);

endmodule

`default_nettype wire

// File: rtl/ps2_keyboard_tx.sv
// ============================================================================
//  Module   : ps2_keyboard_tx
//  Purpose  : Device-side PS/2 keyboard frame transmitter. Accepts a scan code
//             on a valid/ready handshake and serialises it as an 11-bit frame
//             with a device-generated clock. Each bit is driven for one half
//             period with ps2_clk high (SETUP) then held for one half period
//             with ps2_clk low (LOW). A quiet gap of GAP_HALVES half periods
//             follows every frame.
//  Config   : PS2_BREAK_EN - when defined, a request with tx_release=1 sends
//             the break prefix frame 0xF0 followed by the tx_data frame.
//  Ports    : clk        - system clock
//             reset      - asynchronous active-high reset
//             tx_data    - scan code to send
//             tx_release - key-release flag, captured with tx_data
//             tx_valid   - request, taken when tx_ready is high
//             tx_ready   - idle and able to accept
//             ps2_clk    - PS/2 clock, idle high
//             ps2_data   - PS/2 data, idle high
//             busy       - high from acceptance until back in idle
//             frame_done - single-cycle pulse per completed frame
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_keyboard_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HALF   = 2500,
    parameter int GAP_HALVES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_release,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic       frame_done
);

    localparam int            GW       = (GAP_HALVES > 1) ? $clog2(GAP_HALVES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_HALVES - 1);

    ps2_state_t              state_q,      state_d;
    logic [3:0]              bit_idx_q,    bit_idx_d;
    logic [GW-1:0]           gap_idx_q,    gap_idx_d;
    logic [FRAME_BITS-1:0]   frame_q,      frame_d;
    logic [7:0]              hold_q,       hold_d;
    logic                    pending_q,    pending_d;
    logic                    ps2_clk_q,    ps2_clk_d;
    logic                    ps2_data_q,   ps2_data_d;
    logic                    tx_ready_q,   tx_ready_d;
    logic                    busy_q,       busy_d;
    logic                    frame_done_q, frame_done_d;

    logic                    half_tick;
    logic                    accept;
    logic [7:0]              first_code;
    logic                    start_break;

    // tx_ready_q is only ever high in idle, so this is the full handshake.
    assign accept = (state_q == ST_IDLE) && tx_valid && tx_ready_q;

`ifdef PS2_BREAK_EN
    assign first_code  = tx_release ? BREAK_CODE : tx_data;
    assign start_break = tx_release;
`else
    logic unused_release;
    assign unused_release = tx_release;
    assign first_code     = tx_data;
    assign start_break    = 1'b0;
`endif

    ps2_tick_gen #(
        .CLK_HALF (CLK_HALF)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .enable (state_q != ST_IDLE),
        .tick   (half_tick)
    );

    // ------------------------------------------------------------------
    // State register (also registers every datapath and output bit)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            bit_idx_q    <= '0;
            gap_idx_q    <= '0;
            frame_q      <= '1;
            hold_q       <= '0;
            pending_q    <= 1'b0;
            ps2_clk_q    <= 1'b1;
            ps2_data_q   <= 1'b1;
            tx_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            gap_idx_q    <= gap_idx_d;
            frame_q      <= frame_d;
            hold_q       <= hold_d;
            pending_q    <= pending_d;
            ps2_clk_q    <= ps2_clk_d;
            ps2_data_q   <= ps2_data_d;
            tx_ready_q   <= tx_ready_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (half_tick) begin
                    state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                if (half_tick) begin
                    state_d = (bit_idx_q == LAST_BIT) ? ST_GAP : ST_SETUP;
                end
            end
            ST_GAP: begin
                if (half_tick && (gap_idx_q == GAP_LAST)) begin
                    state_d = pending_q ? ST_SETUP : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        bit_idx_d    = bit_idx_q;
        gap_idx_d    = gap_idx_q;
        frame_d      = frame_q;
        hold_d       = hold_q;
        pending_d    = pending_q;
        ps2_clk_d    = ps2_clk_q;
        ps2_data_d   = ps2_data_q;
        tx_ready_d   = tx_ready_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    frame_d    = ps2_frame(first_code);
                    bit_idx_d  = '0;
                    ps2_clk_d  = 1'b1;
                    ps2_data_d = 1'b0;
                    tx_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    if (start_break) begin
                        pending_d = 1'b1;
                        hold_d    = tx_data;
                    end
                end
            end
            ST_SETUP: begin
                if (half_tick) begin
                    ps2_clk_d = 1'b0;
                end
            end
            ST_LOW: begin
                if (half_tick) begin
                    // Data only moves on the rising clock edge.
                    ps2_clk_d = 1'b1;
                    if (bit_idx_q == LAST_BIT) begin
                        ps2_data_d   = 1'b1;
                        frame_done_d = 1'b1;
                        gap_idx_d    = '0;
                    end else begin
                        bit_idx_d  = bit_idx_q + 4'd1;
                        ps2_data_d = frame_q[bit_idx_q + 4'd1];
                    end
                end
            end
            ST_GAP: begin
                if (half_tick) begin
                    if (gap_idx_q == GAP_LAST) begin
                        if (pending_q) begin
                            // Second frame of a release sequence follows
                            // straight on, busy stays high.
                            pending_d  = 1'b0;
                            frame_d    = ps2_frame(hold_q);
                            bit_idx_d  = '0;
                            ps2_data_d = 1'b0;
                        end else begin
                            tx_ready_d = 1'b1;
                            busy_d     = 1'b0;
                        end
                    end else begin
                        gap_idx_d = gap_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                ps2_clk_d  = 1'b1;
                ps2_data_d = 1'b1;
            end
        endcase
    end

    assign tx_ready   = tx_ready_q;
    assign ps2_clk    = ps2_clk_q;
    assign ps2_data   = ps2_data_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

`default_nettype wire
